// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control, zero flag and global stall.
// Define LOGIC_PIPE_PARITY_EN to add a registered `parity` output (XOR-reduce of out).
module logic_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
`ifdef LOGIC_PIPE_PARITY_EN
  output logic             parity,
`endif
  output logic             busy
);

  localparam int unsigned LAST = STAGES - 1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic              zero_q, zero_d;
  logic              adv_c;
  logic [WIDTH-1:0]  result_c;
`ifdef LOGIC_PIPE_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Operation decode; codes 6 and 7 pass operand A through.
  always_comb begin
    result_c = a;
    case (op)
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_XNOR: result_c = ~(a ^ b);
      OP_NAND: result_c = ~(a & b);
      OP_NOR:  result_c = ~(a | b);
      default: result_c = a;
    endcase
  end

  // Whole pipe moves together when the output slot is free or being consumed.
  always_comb begin
    adv_c    = out_ready | ~valid_q[LAST];
    in_ready = adv_c;
    data_d   = data_q;
    valid_d  = valid_q;
    zero_d   = zero_q;
`ifdef LOGIC_PIPE_PARITY_EN
    parity_d = parity_q;
`endif
    if (adv_c) begin
      data_d[0]  = result_c;
      valid_d[0] = in_valid;
      for (int k = 1; k < int'(STAGES); k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // Flags are gated by valid so bubbles never raise them.
      zero_d = valid_d[LAST] & (data_d[LAST] == '0);
`ifdef LOGIC_PIPE_PARITY_EN
      parity_d = valid_d[LAST] & (^data_d[LAST]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
      zero_q  <= 1'b0;
`ifdef LOGIC_PIPE_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
`ifdef LOGIC_PIPE_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign out       = data_q[LAST];
  assign out_valid = valid_q[LAST];
  assign zero      = zero_q;
  assign busy      = |valid_q;
`ifdef LOGIC_PIPE_PARITY_EN
  assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Directed self-checking bench for logic_pipe: reset, latency, all ops, stall, zero flag, parity.
module tb_logic_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 7
);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             busy;
`ifdef LOGIC_PIPE_PARITY_EN
  logic             parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] sa   [16];
  logic [63:0] sb   [16];
  logic [63:0] sexp [16];
  logic [2:0]  sop  [16];
  logic [63:0] ops_exp [8];

  logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
`ifdef LOGIC_PIPE_PARITY_EN
    .parity    (parity),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives sa/sb/sop[0..n-1] and checks outputs in order against sexp; optional output stall window.
  task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
    int idx   = 0;
    int got   = 0;
    int cyc   = 0;
    int first = -1;
    int last  = -1;
    logic [WIDTH-1:0] held = '0;
    logic             held_v = 1'b0;
    logic [WIDTH-1:0] e;
    while (got < n && cyc < 300) begin
      out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (idx < n);
      if (idx < n) begin
        a  = WIDTH'(sa[idx]);
        b  = WIDTH'(sb[idx]);
        op = sop[idx];
      end
      #1;
      if (out_valid && !out_ready) begin
        check({tag, "_stall_in_ready"}, 64'(in_ready), 64'(0));
        if (held_v) check({tag, "_stall_hold"}, 64'(out), 64'(held));
        held   = out;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        e = WIDTH'(sexp[got]);
        check({tag, "_out"}, 64'(out), 64'(e));
        check({tag, "_zero"}, 64'(zero), 64'(e == '0));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) idx++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 64'(got), 64'(n));
    if (stall_at < 0) check({tag, "_rate"}, 64'(last - first), 64'(n - 1));
  endtask

  initial begin
    int emerged;
    int wait_cyc;
    ops_exp[0] = 64'hF000F000F000F000;
    ops_exp[1] = 64'hFFF0FFF0FFF0FFF0;
    ops_exp[2] = 64'h0FF00FF00FF00FF0;
    ops_exp[3] = 64'hF00FF00FF00FF00F;
    ops_exp[4] = 64'h0FFF0FFF0FFF0FFF;
    ops_exp[5] = 64'h000F000F000F000F;
    ops_exp[6] = 64'hFF00FF00FF00FF00;
    ops_exp[7] = 64'hFF00FF00FF00FF00;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 3'd0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef LOGIC_PIPE_PARITY_EN
    check("rst_parity", 64'(parity), 64'(0));
`endif
    rst_n = 1'b1;
    step();

    // Latency: accept at one edge, result visible after STAGES-1 further edges.
    in_valid = 1'b1; op = 3'd2;
    a = WIDTH'(64'h1111111111111111);
    b = WIDTH'(64'h0F0F0F0F0F0F0F0F);
    #1;
    check("lat_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    for (int i = 0; i < int'(STAGES) - 1; i++) begin
      check("lat_early", 64'(out_valid), 64'(0));
      step();
    end
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_out", 64'(out), 64'(WIDTH'(64'h1E1E1E1E1E1E1E1E)));
    check("lat_zero", 64'(zero), 64'(0));
    step();
    check("lat_single", 64'(out_valid), 64'(0));
    check("lat_idle", 64'(busy), 64'(0));

    // All ops back-to-back.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 64'hFF00FF00FF00FF00; sb[i] = 64'hF0F0F0F0F0F0F0F0;
      sop[i] = 3'(i); sexp[i] = ops_exp[i];
    end
    run_stream("ops", 8, -1, 0);

    // Ten inputs with a five-cycle output stall once results are flowing.
    for (int i = 0; i < 10; i++) begin
      sa[i] = 64'hFF00FF00FF00FF00; sb[i] = 64'hF0F0F0F0F0F0F0F0;
      sop[i] = 3'(i % 8); sexp[i] = ops_exp[i % 8];
    end
    run_stream("stall", 10, int'(STAGES) + 1, 5);

    // Zero flag.
    sa[0] = 64'h1111111111111111; sb[0] = 64'h1111111111111111; sop[0] = 3'd2; sexp[0] = 64'h0;
    sa[1] = 64'h1111111111111111; sb[1] = 64'h1111111111111111; sop[1] = 3'd1;
    sexp[1] = 64'h1111111111111111;
    run_stream("zflag", 2, -1, 0);

`ifdef LOGIC_PIPE_PARITY_EN
    in_valid = 1'b1; op = 3'd0; a = WIDTH'(64'h7); b = WIDTH'(64'hF);
    step();
    in_valid = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < int'(STAGES) + 4) begin
      step();
      wait_cyc++;
    end
    check("par_valid", 64'(out_valid), 64'(1));
    check("par_out", 64'(out), 64'(7));
    check("par_bit", 64'(parity), 64'(1));
    step();
    check("par_idle", 64'(parity), 64'(0));
`endif

    // Reset with entries in flight discards them all.
    in_valid = 1'b1; op = 3'd1; a = WIDTH'(64'h5); b = WIDTH'(64'hA);
    repeat (3) step();
    in_valid = 1'b0;
    check("rmid_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    step();
    check("rmid_out_valid", 64'(out_valid), 64'(0));
    check("rmid_busy", 64'(busy), 64'(0));
    check("rmid_zero", 64'(zero), 64'(0));
    rst_n = 1'b1;
    emerged = 0;
    for (int i = 0; i < 2 * int'(STAGES); i++) begin
      step();
      if (out_valid) emerged++;
    end
    check("rmid_emerged", 64'(emerged), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
